// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the core pipeline and the bimodal branch predictor.
// The master modport is the pipeline; the slave modport is the predictor.
interface branch_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] PCF_i;
    logic                  PredTakenF_o;
    logic                  BranchE_i;
    logic [DATA_WIDTH-1:0] PCE_i;
    logic                  BranchTaken_i;
    logic                  PredTakenE_i;
    logic [DATA_WIDTH-1:0] BranchTargetE_i;
    logic [DATA_WIDTH-1:0] PCPlus4E_i;
    logic                  Mispredict_o;
    logic [DATA_WIDTH-1:0] RedirectPC_o;
    logic                  FlushD_o;
    logic                  FlushE_o;
    logic [31:0]           BranchCount_o;
    logic [31:0]           MispredCount_o;

    modport master (
        output PCF_i, BranchE_i, PCE_i, BranchTaken_i, PredTakenE_i,
               BranchTargetE_i, PCPlus4E_i,
        input  PredTakenF_o, Mispredict_o, RedirectPC_o, FlushD_o, FlushE_o,
               BranchCount_o, MispredCount_o
    );

    modport slave (
        input  PCF_i, BranchE_i, PCE_i, BranchTaken_i, PredTakenE_i,
               BranchTargetE_i, PCPlus4E_i,
        output PredTakenF_o, Mispredict_o, RedirectPC_o, FlushD_o, FlushE_o,
               BranchCount_o, MispredCount_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: PC-indexed table of 2-bit saturating counters, plus a one-cycle
// misprediction recovery FSM that redirects fetch, flushes D/E and keeps branch statistics.
module branch_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    branch_predictor_if.slave  bus
);
    localparam int INDEX_BITS = $clog2(BHT_ENTRIES);

    typedef enum logic {
        IDLE,
        RECOVER
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              bht_q [BHT_ENTRIES];
    logic [31:0]             branchCount_q, branchCount_d;
    logic [31:0]             mispredCount_q, mispredCount_d;

    logic [INDEX_BITS-1:0]   pcfIdx;
    logic [INDEX_BITS-1:0]   pceIdx;
    logic                    resolveValid;
    logic                    mispredict;
    logic [1:0]              ctrCur;
    logic [1:0]              ctrNext;
    logic [DATA_WIDTH-1:0]   redirectPc;

    assign pcfIdx = bus.PCF_i[INDEX_BITS+1:2];
    assign pceIdx = bus.PCE_i[INDEX_BITS+1:2];

    // Gating with rst_n_i keeps the redirect outputs quiet while reset is held.
    assign resolveValid = bus.BranchE_i && (state_q == IDLE) && rst_n_i;
    assign mispredict   = resolveValid && (bus.BranchTaken_i != bus.PredTakenE_i);
    assign ctrCur       = bht_q[pceIdx];

    always_comb begin
        ctrNext = ctrCur;
        if (bus.BranchTaken_i) begin
            if (ctrCur != 2'b11) ctrNext = ctrCur + 2'b01;
        end else begin
            if (ctrCur != 2'b00) ctrNext = ctrCur - 2'b01;
        end
    end

    always_comb begin
        redirectPc = '0;
        if (mispredict) begin
            redirectPc = bus.BranchTaken_i ? bus.BranchTargetE_i : bus.PCPlus4E_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mispredict) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        branchCount_d  = branchCount_q;
        mispredCount_d = mispredCount_q;
        if (resolveValid && (branchCount_q != 32'hFFFF_FFFF)) begin
            branchCount_d = branchCount_q + 32'd1;
        end
        if (mispredict && (mispredCount_q != 32'hFFFF_FFFF)) begin
            mispredCount_d = mispredCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            branchCount_q  <= '0;
            mispredCount_q <= '0;
        end else begin
            state_q        <= state_d;
            branchCount_q  <= branchCount_d;
            mispredCount_q <= mispredCount_d;
        end
    end

    // Fetch reads bht_q combinationally, so a same-cycle update is seen only after the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolveValid) begin
            bht_q[pceIdx] <= ctrNext;
        end
    end

    assign bus.PredTakenF_o   = bht_q[pcfIdx][1];
    assign bus.Mispredict_o   = mispredict;
    assign bus.FlushD_o       = mispredict;
    assign bus.FlushE_o       = mispredict;
    assign bus.RedirectPC_o   = redirectPc;
    assign bus.BranchCount_o  = branchCount_q;
    assign bus.MispredCount_o = mispredCount_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random traffic,
// all compared against a counter-table reference model kept in plain integer arrays.
module tb_branch_predictor;
    logic clk;
    logic rstN;

    branch_predictor_if #(.DATA_WIDTH(32)) bus ();

    branch_predictor #(
        .DATA_WIDTH (32),
        .BHT_ENTRIES(64)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rstN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;

    int     modelCtr [64];
    longint modelBranches;
    longint modelMispreds;
    bit     modelRecover;

    function automatic int tableIndex(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic [31:0] satCount(input longint n);
        return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 64; i++) modelCtr[i] = 1;
        modelBranches = 0;
        modelMispreds = 0;
        modelRecover  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        bus.PCF_i           = '0;
        bus.BranchE_i       = 1'b0;
        bus.PCE_i           = '0;
        bus.BranchTaken_i   = 1'b0;
        bus.PredTakenE_i    = 1'b0;
        bus.BranchTargetE_i = '0;
        bus.PCPlus4E_i      = '0;
    endtask

    // One clock of traffic: drive after the falling edge, check before the rising edge,
    // then advance the model by the rules of a bimodal predictor.
    task automatic applyStimulus(input logic [31:0] pcf, input logic be,
                                 input logic [31:0] pce, input logic taken,
                                 input logic predE, input logic [31:0] target,
                                 input logic [31:0] plus4);
        bit          valid;
        bit          mis;
        logic [31:0] expRedirect;
        @(negedge clk);
        bus.PCF_i           = pcf;
        bus.BranchE_i       = be;
        bus.PCE_i           = pce;
        bus.BranchTaken_i   = taken;
        bus.PredTakenE_i    = predE;
        bus.BranchTargetE_i = target;
        bus.PCPlus4E_i      = plus4;
        #1;
        valid       = be && !modelRecover;
        mis         = valid && (taken != predE);
        expRedirect = mis ? (taken ? target : plus4) : 32'h0;
        checkOutput("PredTakenF",   {31'b0, bus.PredTakenF_o}, {31'b0, modelCtr[tableIndex(pcf)] >= 2});
        checkOutput("Mispredict",   {31'b0, bus.Mispredict_o}, {31'b0, mis});
        checkOutput("FlushD",       {31'b0, bus.FlushD_o},     {31'b0, mis});
        checkOutput("FlushE",       {31'b0, bus.FlushE_o},     {31'b0, mis});
        checkOutput("RedirectPC",   bus.RedirectPC_o,          expRedirect);
        checkOutput("BranchCount",  bus.BranchCount_o,         satCount(modelBranches));
        checkOutput("MispredCount", bus.MispredCount_o,        satCount(modelMispreds));
        @(posedge clk);
        if (valid) begin
            int i = tableIndex(pce);
            modelCtr[i] = taken ? ((modelCtr[i] + 1 > 3) ? 3 : modelCtr[i] + 1)
                                : ((modelCtr[i] - 1 < 0) ? 0 : modelCtr[i] - 1);
            modelBranches++;
            if (mis) modelMispreds++;
        end
        modelRecover = mis;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_Mispredict"},   {31'b0, bus.Mispredict_o}, 32'h0);
        checkOutput({tag, "_FlushD"},       {31'b0, bus.FlushD_o},     32'h0);
        checkOutput({tag, "_FlushE"},       {31'b0, bus.FlushE_o},     32'h0);
        checkOutput({tag, "_RedirectPC"},   bus.RedirectPC_o,          32'h0);
        checkOutput({tag, "_BranchCount"},  bus.BranchCount_o,         32'h0);
        checkOutput({tag, "_MispredCount"}, bus.MispredCount_o,        32'h0);
        for (int pc = 0; pc < 256; pc += 4) begin
            bus.PCF_i = 32'(pc);
            #1;
            checkOutput({tag, "_TableSweep"}, {31'b0, bus.PredTakenF_o}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] pce;
        logic        taken;
        logic        predE;
        rstN = 1'b0;
        idleInputs();
        resetModel();
        bus.BranchE_i     = 1'b1;
        bus.BranchTaken_i = 1'b1;
        #1;
        checkResetState("reset");
        idleInputs();
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] taken branch predicted not-taken at 0x100");
        applyStimulus(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] mispredict with BranchE held through recovery");
        applyStimulus(32'h0, 1'b1, 32'h140, 1'b1, 1'b0, 32'h300, 32'h144);
        applyStimulus(32'h140, 1'b1, 32'h140, 1'b1, 1'b0, 32'h300, 32'h144);
        applyStimulus(32'h140, 1'b1, 32'h140, 1'b1, 1'b1, 32'h300, 32'h144);

        $display("[TB] predicted taken, actually not-taken");
        applyStimulus(32'h0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] saturation from reset and same-index lookup during update");
        @(negedge clk);
        rstN = 1'b0;
        resetModel();
        #1;
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
        end
        applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(32'h0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h80, 32'h204);
        applyStimulus(32'h0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h40, 32'h8);
        applyStimulus(32'h4, 1'b1, 32'h4, 1'b1, 1'b1, 32'h40, 32'h8);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            pce   = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            taken = 1'($urandom_range(0, 1));
            predE = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1))
                                                : 1'(modelCtr[tableIndex(pce)] >= 2);
            applyStimulus(32'($urandom_range(0, 1023)), 1'($urandom_range(0, 3) != 0),
                          pce, taken, predE, $urandom, pce + 32'd4);
        end

        $display("[TB] reset asserted mid-recovery");
        applyStimulus(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
        checkOutput("enteredRecover", {31'b0, modelRecover}, 32'h1);
        #2;
        bus.BranchE_i     = 1'b1;
        bus.PCE_i         = 32'h100;
        bus.BranchTaken_i = 1'b0;
        bus.PredTakenE_i  = 1'b1;
        rstN = 1'b0;
        resetModel();
        #1;
        checkResetState("midReset");
        idleInputs();
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
